// File: rtl/if_id_fetch_stage.sv
// rtl/if_id_fetch_stage.sv - IF/ID stage: ROM address drive, ID latch, stall/halt hold, perf counters
// The instruction shown in ID comes straight from the ROM in RUN, or from a hold register while stalled/halted.

module if_id_fetch_stage #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              pc_bj,
  input  logic              nop_lock_id,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc_if_id,
  output logic [DATA_W-1:0] instr_if_id,
  output logic              valid_if_id,
  output logic [31:0]       fetch_count,
  output logic [31:0]       redirect_count,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_STALL  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc_if_id;
  logic [ADDR_W-1:0] w_pc_if_id_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic [DATA_W-1:0] r_hold_instr;
  logic [DATA_W-1:0] w_hold_instr_nxt;
  logic [31:0]       r_fetch_count;
  logic [31:0]       w_fetch_count_nxt;
  logic [31:0]       r_redirect_count;
  logic [31:0]       w_redirect_count_nxt;
  logic [31:0]       r_stall_cycles;
  logic [31:0]       w_stall_cycles_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_RUN;
      // All-ones so the PC stage's pc_if_id+1 makes the first fetch address 0.
      r_pc_if_id       <= '1;
      r_valid          <= 1'b0;
      r_hold_instr     <= NOP_INSTR;
      r_fetch_count    <= '0;
      r_redirect_count <= '0;
      r_stall_cycles   <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_pc_if_id       <= w_pc_if_id_nxt;
      r_valid          <= w_valid_nxt;
      r_hold_instr     <= w_hold_instr_nxt;
      r_fetch_count    <= w_fetch_count_nxt;
      r_redirect_count <= w_redirect_count_nxt;
      r_stall_cycles   <= w_stall_cycles_nxt;
    end
  end

  always_comb begin
    w_state_nxt          = r_state;
    w_pc_if_id_nxt       = r_pc_if_id;
    w_valid_nxt          = r_valid;
    w_hold_instr_nxt     = r_hold_instr;
    w_fetch_count_nxt    = r_fetch_count;
    w_redirect_count_nxt = r_redirect_count;
    w_stall_cycles_nxt   = r_stall_cycles;
    if (halt) begin
      w_state_nxt        = S_HALTED;
      w_stall_cycles_nxt = r_stall_cycles + 32'd1;
      if (r_state == S_RUN) begin
        w_hold_instr_nxt = imem_rdata;
      end
    end else if (pc_bj) begin
      w_state_nxt          = S_RUN;
      w_pc_if_id_nxt       = pc_in;
      w_valid_nxt          = 1'b1;
      w_fetch_count_nxt    = r_fetch_count + 32'd1;
      w_redirect_count_nxt = r_redirect_count + 32'd1;
    end else if (nop_lock_id) begin
      // Only RUN still has the ID word on the ROM bus; other states already hold it.
      w_state_nxt        = S_STALL;
      w_stall_cycles_nxt = r_stall_cycles + 32'd1;
      if (r_state == S_RUN) begin
        w_hold_instr_nxt = imem_rdata;
      end
    end else begin
      w_state_nxt       = S_RUN;
      w_pc_if_id_nxt    = pc_in;
      w_valid_nxt       = 1'b1;
      w_fetch_count_nxt = r_fetch_count + 32'd1;
    end
  end

  always_comb begin
    instr_if_id = NOP_INSTR;
    if (r_valid) begin
      instr_if_id = (r_state == S_RUN) ? imem_rdata : r_hold_instr;
    end
  end

  assign imem_addr      = pc_in;
  assign pc_if_id       = r_pc_if_id;
  assign valid_if_id    = r_valid;
  assign fetch_count    = r_fetch_count;
  assign redirect_count = r_redirect_count;
  assign stall_cycles   = r_stall_cycles;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb/tb_if_id_fetch_stage.sv - scoreboard bench for if_id_fetch_stage with a 1-cycle ROM model

module tb_if_id_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic        pc_bj = 1'b0;
  logic        nop_lock_id = 1'b0;
  logic [31:0] pc_in = 32'h20;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_if_id;
  logic [31:0] instr_if_id;
  logic        valid_if_id;
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;
  logic [31:0] stall_cycles;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        chk_cnt;
    logic [31:0] fc;
    logic [31:0] rc;
    logic [31:0] sc;
  } exp_t;

  exp_t exp_q[$];

  if_id_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .halt           (halt),
    .pc_bj          (pc_bj),
    .nop_lock_id    (nop_lock_id),
    .pc_in          (pc_in),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .pc_if_id       (pc_if_id),
    .instr_if_id    (instr_if_id),
    .valid_if_id    (valid_if_id),
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: word[a] = a + 0x100, one cycle of latency.
  always @(posedge clk) imem_rdata <= imem_addr + 32'h100;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show after that edge.
  task automatic cyc(input logic r, input logic h, input logic bj, input logic lk,
                     input logic [31:0] pin, input logic [31:0] epc, input logic [31:0] ein,
                     input logic ev, input logic cc, input logic [31:0] efc,
                     input logic [31:0] erc, input logic [31:0] esc);
    exp_t e;
    @(negedge clk);
    rst = r; halt = h; pc_bj = bj; nop_lock_id = lk; pc_in = pin;
    e.pc = epc; e.instr = ein; e.valid = ev; e.chk_cnt = cc;
    e.fc = efc; e.rc = erc; e.sc = esc;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check32("pc_if_id", pc_if_id, e.pc);
      check32("instr_if_id", instr_if_id, e.instr);
      check32("valid_if_id", {31'd0, valid_if_id}, {31'd0, e.valid});
      if (e.chk_cnt) begin
        check32("fetch_count", fetch_count, e.fc);
        check32("redirect_count", redirect_count, e.rc);
        check32("stall_cycles", stall_cycles, e.sc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    // 1: reset two cycles (ROM bus busy with 0x120, output must stay NOP), then free-run
    cyc(1,0,0,0, 32'h20, 32'hFFFF_FFFF, 32'h0, 0, 1, 0, 0, 0);
    cyc(1,0,0,0, 32'h20, 32'hFFFF_FFFF, 32'h0, 0, 1, 0, 0, 0);
    cyc(0,0,0,0, 32'h0,  32'h0, 32'h100, 1, 1, 1, 0, 0);
    cyc(0,0,0,0, 32'h1,  32'h1, 32'h101, 1, 0, 0, 0, 0);
    cyc(0,0,0,0, 32'h2,  32'h2, 32'h102, 1, 0, 0, 0, 0);
    cyc(0,0,0,0, 32'h3,  32'h3, 32'h103, 1, 1, 4, 0, 0);
    cyc(0,0,0,0, 32'h4,  32'h4, 32'h104, 1, 0, 0, 0, 0);
    cyc(0,0,0,0, 32'h5,  32'h5, 32'h105, 1, 1, 6, 0, 0);
    // 2: load-use stall for 3 cycles while the ROM address moves
    cyc(0,0,0,1, 32'h77, 32'h5, 32'h105, 1, 1, 6, 0, 1);
    cyc(0,0,0,1, 32'h33, 32'h5, 32'h105, 1, 1, 6, 0, 2);
    cyc(0,0,0,1, 32'h6,  32'h5, 32'h105, 1, 1, 6, 0, 3);
    cyc(0,0,0,0, 32'h6,  32'h6, 32'h106, 1, 1, 7, 0, 3);
    // 3: redirect wins over a simultaneous stall and discards the pending hold
    cyc(0,0,0,0, 32'h7,  32'h7, 32'h107, 1, 0, 0, 0, 0);
    cyc(0,0,0,1, 32'h8,  32'h7, 32'h107, 1, 1, 8, 0, 4);
    cyc(0,0,1,1, 32'h40, 32'h40, 32'h140, 1, 1, 9, 1, 4);
    cyc(0,0,0,0, 32'h41, 32'h41, 32'h141, 1, 1, 10, 1, 4);
    // 4: halt 5 cycles at pc 9; a redirect during halt is ignored
    cyc(0,0,1,0, 32'h9,  32'h9, 32'h109, 1, 1, 11, 2, 4);
    cyc(0,1,0,0, 32'hA,  32'h9, 32'h109, 1, 1, 11, 2, 5);
    cyc(0,1,0,0, 32'hA,  32'h9, 32'h109, 1, 1, 11, 2, 6);
    cyc(0,1,1,0, 32'h55, 32'h9, 32'h109, 1, 1, 11, 2, 7);
    cyc(0,1,0,0, 32'hA,  32'h9, 32'h109, 1, 1, 11, 2, 8);
    cyc(0,1,0,0, 32'hA,  32'h9, 32'h109, 1, 1, 11, 2, 9);
    cyc(0,0,0,0, 32'hA,  32'hA, 32'h10A, 1, 1, 12, 2, 9);
    // 5: reset during STALL clears everything; fetch restarts at 0
    cyc(0,0,0,1, 32'hB,  32'hA, 32'h10A, 1, 1, 12, 2, 10);
    cyc(1,0,0,1, 32'hB,  32'hFFFF_FFFF, 32'h0, 0, 1, 0, 0, 0);
    cyc(0,0,0,0, 32'h0,  32'h0, 32'h100, 1, 1, 1, 0, 0);
    // 6: redirect to all-ones then advance across the wrap
    cyc(0,0,1,0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF, 1, 1, 2, 1, 0);
    cyc(0,0,0,0, 32'h0,  32'h0, 32'h100, 1, 1, 3, 1, 0);

    @(negedge clk);
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
